// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions for the decoder, multiplier_top and divider_top.
// Holds the datapath width, divider FSM states and the division boundary constants.
package rv32m_pkg;

  localparam int XLEN     = 32;
  localparam int DIV_ITER = 32;

  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    SPECIAL
  } div_state_t;

  // Two's complement magnitude when the operand is treated as signed.
  function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic en);
    return (en && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {r,q} left and try to subtract d.
// Purely combinational so it can be chained for an unrolled divider later.
module div_step
  import rv32m_pkg::*;
(
  input  logic [XLEN-1:0] i_r,
  input  logic [XLEN-1:0] i_q,
  input  logic [XLEN-1:0] i_d,
  output logic [XLEN-1:0] o_r,
  output logic [XLEN-1:0] o_q
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_trial;

  // r < d always holds, so the shifted partial remainder fits in XLEN+1 bits.
  assign w_shift = {i_r, i_q[XLEN-1]};
  assign w_trial = w_shift - {1'b0, i_d};

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_r = w_shift[XLEN-1:0];
    o_q = {i_q[XLEN-2:0], 1'b0};
    if (!w_trial[XLEN]) begin
      o_r = w_trial[XLEN-1:0];
      o_q = {i_q[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/divider_top.sv
// Sequential RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// The result is registered and held until the next operation completes.
module divider_top
  import rv32m_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            div_en_i,
  input  logic [XLEN-1:0] op_A_i,
  input  logic [XLEN-1:0] op_B_i,
  input  logic            signed_i,
  input  logic            rem_i,
  output logic [XLEN-1:0] result_o,
  output logic            done_o,
  output logic            busy_o
);

  div_state_t r_state;
  div_state_t w_next;

  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_cnt;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_sel_rem;
  logic            r_done;

  logic [XLEN-1:0] w_step_r;
  logic [XLEN-1:0] w_step_q;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic            w_div_zero;
  logic            w_overflow;
  logic            w_last;

  assign w_div_zero = (op_B_i == '0);
  assign w_overflow = signed_i && (op_A_i == INT_MIN) && (op_B_i == ALL_ONES);
  assign w_last     = (r_cnt == 5'(DIV_ITER - 1));

  assign w_q_fix = negate_if(r_quo, r_neg_q);
  assign w_r_fix = negate_if(r_rem, r_neg_r);

  div_step u_step (
    .i_r (r_rem),
    .i_q (r_quo),
    .i_d (r_div),
    .o_r (w_step_r),
    .o_q (w_step_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // FIX and SPECIAL stay put through the done_o cycle so busy_o covers it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:         if (div_en_i) w_next = (w_div_zero || w_overflow) ? SPECIAL : CALC;
      CALC:         if (w_last)   w_next = FIX;
      FIX, SPECIAL: if (r_done)   w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: every register, including the datapath, is reset so an aborted
    // operation leaves no stale state behind.
    if (!rst_ni) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_sel_rem <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (div_en_i) begin
            r_sel_rem <= rem_i;
            r_cnt     <= '0;
            r_div     <= abs_if(op_B_i, signed_i);
            if (w_div_zero) begin
              // Special results are preloaded so SPECIAL reuses the FIX path.
              r_quo   <= ALL_ONES;
              r_rem   <= op_A_i;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else if (w_overflow) begin
              r_quo   <= INT_MIN;
              r_rem   <= '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_quo   <= abs_if(op_A_i, signed_i);
              r_rem   <= '0;
              r_neg_q <= signed_i & (op_A_i[XLEN-1] ^ op_B_i[XLEN-1]);
              r_neg_r <= signed_i & op_A_i[XLEN-1];
            end
          end
        end
        CALC: begin
          r_rem <= w_step_r;
          r_quo <= w_step_q;
          r_cnt <= r_cnt + 5'd1;
        end
        FIX, SPECIAL: begin
          if (!r_done) begin
            r_result <= r_sel_rem ? w_r_fix : w_q_fix;
            r_done   <= 1'b1;
          end else begin
            r_done   <= 1'b0;
          end
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign result_o = r_result;
  assign done_o   = r_done;
  assign busy_o   = (r_state != IDLE);

endmodule

// File: tb/tb_divider_top.sv
// Self-checking bench for divider_top: directed RV32M corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_divider_top;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        div_en_i;
  logic [31:0] op_A_i;
  logic [31:0] op_B_i;
  logic        signed_i;
  logic        rem_i;
  logic [31:0] result_o;
  logic        done_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  localparam int LAT_NORMAL  = 33;
  localparam int LAT_SPECIAL = 1;
  localparam int MAX_WAIT    = 100;

  always #5 clk_i = ~clk_i;

  divider_top dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .div_en_i (div_en_i),
    .op_A_i   (op_A_i),
    .op_B_i   (op_B_i),
    .signed_i (signed_i),
    .rem_i    (rem_i),
    .result_o (result_o),
    .done_o   (done_o),
    .busy_o   (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V M semantics from 64-bit integer arithmetic (truncating division).
  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic rem);
    longint sa, sb, q, r;
    if (b == 32'h0) return rem ? a : 32'hFFFF_FFFF;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'h0, a};
      sb = {32'h0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return rem ? r[31:0] : q[31:0];
  endfunction

  // Starts one operation and returns the result and the edge index of done_o
  // (start edge = 0). With mangle set, the inputs are scrambled mid-operation.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic rem, input logic mangle,
                       output logic [31:0] res, output int lat);
    @(negedge clk_i);
    op_A_i = a; op_B_i = b; signed_i = s; rem_i = rem; div_en_i = 1'b1;
    @(posedge clk_i);
    #1 div_en_i = 1'b0;
    check("busy_after_start", {31'b0, busy_o}, 32'd1);
    lat = 0;
    while (lat < MAX_WAIT) begin
      @(posedge clk_i);
      lat++;
      #1;
      if (mangle && lat == 5) begin
        op_A_i = 32'h0; op_B_i = 32'h0; signed_i = ~s; rem_i = ~rem;
      end
      if (done_o) break;
    end
    res = result_o;
    check("busy_in_done", {31'b0, busy_o}, 32'd1);
    @(posedge clk_i);
    #1;
    check("done_single_pulse", {31'b0, done_o}, 32'd0);
    check("idle_after_done", {31'b0, busy_o}, 32'd0);
    check("result_held", result_o, res);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic rem, input logic [31:0] exp,
                     input int exp_lat, input logic mangle);
    logic [31:0] res;
    int          lat;
    do_op(a, b, s, rem, mangle, res, lat);
    check({tag, "_result"}, res, exp);
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    int          done_edges[$];
    int          edge_cnt;
    int          busy_low;
    logic [31:0] ra, rb, rexp;
    logic        rs, rr;
    int          rexp_lat;

    rst_ni = 1'b0; div_en_i = 1'b0; op_A_i = '0; op_B_i = '0; signed_i = 1'b0; rem_i = 1'b0;
    #12;
    check("reset_result", result_o, 32'h0);
    check("reset_done", {31'b0, done_o}, 32'd0);
    check("reset_busy", {31'b0, busy_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Unsigned and signed reference cases.
    run("divu", 32'h8000_0001, 32'h0001_0002, 1'b0, 1'b0, 32'h0000_7FFF, LAT_NORMAL, 1'b0);
    run("remu", 32'h8000_0001, 32'h0001_0002, 1'b0, 1'b1, 32'h0000_0003, LAT_NORMAL, 1'b0);
    run("div",  32'h8000_0001, 32'h0001_0002, 1'b1, 1'b0, 32'hFFFF_8001, LAT_NORMAL, 1'b0);
    run("rem",  32'h8000_0001, 32'h0001_0002, 1'b1, 1'b1, 32'hFFFF_FFFF, LAT_NORMAL, 1'b0);

    // Divide by zero and signed overflow.
    run("div_by0",  32'h7, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFF, LAT_SPECIAL, 1'b0);
    run("rem_by0",  32'h7, 32'h0, 1'b1, 1'b1, 32'h0000_0007, LAT_SPECIAL, 1'b0);
    run("divu_by0", 32'h7, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF, LAT_SPECIAL, 1'b0);
    run("div_ovf",  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, LAT_SPECIAL, 1'b0);
    run("rem_ovf",  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000, LAT_SPECIAL, 1'b0);
    run("divu_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, LAT_NORMAL, 1'b0);

    // Reset mid-operation: operand change at cycle 5, reset at cycle 10.
    @(negedge clk_i);
    op_A_i = 32'd100; op_B_i = 32'd7; signed_i = 1'b0; rem_i = 1'b0; div_en_i = 1'b1;
    @(posedge clk_i);
    #1 div_en_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1 op_A_i = 32'h0;
    repeat (5) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    check("abort_result", result_o, 32'h0);
    check("abort_busy", {31'b0, busy_o}, 32'd0);
    check("abort_done", {31'b0, done_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1 check("abort_no_done", {31'b0, done_o}, 32'd0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    run("restart_divu", 32'd100, 32'd7, 1'b0, 1'b0, 32'h0000_000E, LAT_NORMAL, 1'b0);
    run("restart_remu", 32'd100, 32'd7, 1'b0, 1'b1, 32'h0000_0002, LAT_NORMAL, 1'b0);
    run("mangled_divu", 32'd100, 32'd7, 1'b0, 1'b0, 32'h0000_000E, LAT_NORMAL, 1'b1);

    // div_en_i held high: back-to-back operations.
    @(negedge clk_i);
    op_A_i = 32'd9; op_B_i = 32'hFFFF_FFFD; signed_i = 1'b1; rem_i = 1'b0; div_en_i = 1'b1;
    edge_cnt = 0;
    busy_low = 0;
    while (done_edges.size() < 3 && edge_cnt < 200) begin
      @(posedge clk_i);
      edge_cnt++;
      #1;
      if (done_o) begin
        done_edges.push_back(edge_cnt);
        check("b2b_result", result_o, 32'hFFFF_FFFD);
      end
      if (done_edges.size() == 1 && !busy_o) busy_low++;
    end
    @(negedge clk_i);
    div_en_i = 1'b0;
    check("b2b_pulses", done_edges.size(), 32'd3);
    if (done_edges.size() == 3) begin
      check("b2b_first", done_edges[0], 32'd34);
      check("b2b_period1", done_edges[1] - done_edges[0], 32'd35);
      check("b2b_period2", done_edges[2] - done_edges[1], 32'd35);
    end
    check("b2b_busy_gap", busy_low, 32'd1);
    repeat (3) @(posedge clk_i);
    #1 check("b2b_idle", {31'b0, busy_o}, 32'd0);

    // Random operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = -32'($urandom_range(1, 15));
        default: ;
      endcase
      rexp     = ref_model(ra, rb, rs, rr);
      rexp_lat = (rb == 32'h0 || (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF))
                 ? LAT_SPECIAL : LAT_NORMAL;
      run("random", ra, rb, rs, rr, rexp, rexp_lat, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
